// File: rtl/dm_dmi_bridge.sv
// rtl/dm_dmi_bridge.sv - System-clock DMI endpoint bridging DTM handshakes to the DM register bank
module dm_dmi_bridge #(
  parameter int DMI_ADDR_BITS  = 6,
  parameter int DMI_DATA_BITS  = 32,
  parameter int DMI_OP_BITS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               dtm_req_i,
  input  logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] dtm_req_data_i,
  output logic                                               dtm_ack_o,
  output logic                                               dm_resp_o,
  output logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] dm_resp_data_o,
  input  logic                                               dtm_resp_ack_i,
  output logic                                               reg_req_o,
  output logic                                               reg_we_o,
  output logic [DMI_ADDR_BITS-1:0]                           reg_addr_o,
  output logic [DMI_DATA_BITS-1:0]                           reg_wdata_o,
  input  logic                                               reg_ack_i,
  input  logic [DMI_DATA_BITS-1:0]                           reg_rdata_i
);

  localparam int W     = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0]         CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DMI_OP_BITS-1:0]   OP_NOP    = DMI_OP_BITS'(0);
  localparam logic [DMI_OP_BITS-1:0]   OP_READ   = DMI_OP_BITS'(1);
  localparam logic [DMI_OP_BITS-1:0]   OP_WRITE  = DMI_OP_BITS'(2);
  localparam logic [DMI_OP_BITS-1:0]   OP_FAIL   = DMI_OP_BITS'(2);
  localparam logic [DMI_DATA_BITS-1:0] ZERO_DATA = '0;

  typedef enum logic [2:0] {
    IDLE,
    REQ_REL,
    ACCESS,
    RESP_SETUP,
    RESP_REQ,
    RESP_REL
  } state_t;

  state_t                   state;
  logic                     req_s1, req_s;
  logic                     ack_s1, ack_s;
  logic [DMI_ADDR_BITS-1:0] addr_q;
  logic [DMI_DATA_BITS-1:0] data_q;
  logic [DMI_OP_BITS-1:0]   op_q;
  logic [CNT_W-1:0]         cnt;

  // Address and write data are presented straight from the latched request
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = data_q;

  // Two-flop synchronizers for the TCK-domain handshake levels
  always_ff @(posedge clk) begin
    if (rst) begin
      req_s1 <= 1'b0;
      req_s  <= 1'b0;
      ack_s1 <= 1'b0;
      ack_s  <= 1'b0;
    end else begin
      req_s1 <= dtm_req_i;
      req_s  <= req_s1;
      ack_s1 <= dtm_resp_ack_i;
      ack_s  <= ack_s1;
    end
  end

  // Request capture, bank access with timeout, and response handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      addr_q         <= '0;
      data_q         <= '0;
      op_q           <= '0;
      cnt            <= '0;
      dtm_ack_o      <= 1'b0;
      dm_resp_o      <= 1'b0;
      dm_resp_data_o <= '0;
      reg_req_o      <= 1'b0;
      reg_we_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_s) begin
            addr_q    <= dtm_req_data_i[W-1 -: DMI_ADDR_BITS];
            data_q    <= dtm_req_data_i[DMI_OP_BITS +: DMI_DATA_BITS];
            op_q      <= dtm_req_data_i[DMI_OP_BITS-1:0];
            dtm_ack_o <= 1'b1;
            state     <= REQ_REL;
          end
        end
        REQ_REL: begin
          if (!req_s) begin
            dtm_ack_o <= 1'b0;
            cnt       <= '0;
            if (op_q == OP_READ || op_q == OP_WRITE) begin
              reg_req_o <= 1'b1;
              reg_we_o  <= (op_q == OP_WRITE);
              state     <= ACCESS;
            end else begin
              // Anything other than nop is a reserved op and reports failure
              dm_resp_data_o <= {addr_q, ZERO_DATA, (op_q == OP_NOP) ? OP_NOP : OP_FAIL};
              state          <= RESP_SETUP;
            end
          end
        end
        ACCESS: begin
          // An ack arriving in the expiry cycle still completes the access
          if (reg_ack_i) begin
            reg_req_o      <= 1'b0;
            reg_we_o       <= 1'b0;
            dm_resp_data_o <= {addr_q, reg_we_o ? data_q : reg_rdata_i, OP_NOP};
            state          <= RESP_SETUP;
          end else if (cnt == CNT_LAST) begin
            reg_req_o      <= 1'b0;
            reg_we_o       <= 1'b0;
            dm_resp_data_o <= {addr_q, ZERO_DATA, OP_FAIL};
            state          <= RESP_SETUP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP_SETUP: begin
          // Response word has been stable for a cycle before the level rises
          dm_resp_o <= 1'b1;
          state     <= RESP_REQ;
        end
        RESP_REQ: begin
          if (ack_s) begin
            dm_resp_o <= 1'b0;
            state     <= RESP_REL;
          end
        end
        RESP_REL: begin
          if (!ack_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_dmi_bridge.sv
// tb/tb_dm_dmi_bridge.sv - Scoreboard bench for dm_dmi_bridge
module tb_dm_dmi_bridge;
  localparam int AB = 6, DB = 32, OB = 2, W = AB + DB + OB, TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dtm_req_i = 1'b0;
  logic [W-1:0]  dtm_req_data_i = '0;
  logic          dtm_ack_o;
  logic          dm_resp_o;
  logic [W-1:0]  dm_resp_data_o;
  logic          dtm_resp_ack_i = 1'b0;
  logic          reg_req_o;
  logic          reg_we_o;
  logic [AB-1:0] reg_addr_o;
  logic [DB-1:0] reg_wdata_o;
  logic          reg_ack_i = 1'b0;
  logic [DB-1:0] reg_rdata_i = '0;

  always #5 clk = ~clk;

  dm_dmi_bridge #(
    .DMI_ADDR_BITS(AB), .DMI_DATA_BITS(DB), .DMI_OP_BITS(OB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .dtm_req_i(dtm_req_i), .dtm_req_data_i(dtm_req_data_i), .dtm_ack_o(dtm_ack_o),
    .dm_resp_o(dm_resp_o), .dm_resp_data_o(dm_resp_data_o), .dtm_resp_ack_i(dtm_resp_ack_i),
    .reg_req_o(reg_req_o), .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_ack_i(reg_ack_i), .reg_rdata_i(reg_rdata_i)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb[$];

  // Register bank model state
  bit            bank_on = 1'b0;
  int            bank_delay = 0;
  logic [DB-1:0] bank_rdata = '0;
  int            acc_count = 0;
  int            hi_cyc = 0;
  bit            in_acc = 1'b0;
  bit            stable_bad = 1'b0;
  logic          cap_we = 1'b0;
  logic [AB-1:0] cap_addr = '0;
  logic [DB-1:0] cap_wdata = '0;

  function automatic logic [W-1:0] mk(input logic [AB-1:0] a, input logic [DB-1:0] d,
                                      input logic [OB-1:0] o);
    return {a, d, o};
  endfunction

  // Bank: acks bank_delay cycles after the request rises, records what it saw
  initial begin
    forever begin
      @(negedge clk);
      reg_ack_i = 1'b0;
      if (reg_req_o === 1'b1) begin
        if (!in_acc) begin
          in_acc     = 1'b1;
          acc_count  = acc_count + 1;
          hi_cyc     = 0;
          stable_bad = 1'b0;
          cap_we     = reg_we_o;
          cap_addr   = reg_addr_o;
          cap_wdata  = reg_wdata_o;
        end
        hi_cyc = hi_cyc + 1;
        if (reg_we_o !== cap_we || reg_addr_o !== cap_addr || reg_wdata_o !== cap_wdata)
          stable_bad = 1'b1;
        if (bank_on && hi_cyc == bank_delay + 1) begin
          reg_ack_i   = 1'b1;
          reg_rdata_i = bank_rdata;
        end
      end else begin
        in_acc = 1'b0;
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic raise_req(input logic [W-1:0] word);
    @(negedge clk);
    dtm_req_data_i = word;
    dtm_req_i      = 1'b1;
  endtask

  task automatic wait_ack(input string name, output int n);
    n = 0;
    while (dtm_ack_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dtm_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_ack: dtm_ack_o=%b required 1", name, dtm_ack_o);
    end
  endtask

  task automatic release_req(output int n_fall, output int n_resp);
    int n;
    dtm_req_i = 1'b0;
    n = 0; n_fall = -1; n_resp = -1;
    while (n < 200 && dm_resp_o !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n_fall < 0 && dtm_ack_o === 1'b0) n_fall = n;
    end
    if (dm_resp_o === 1'b1) n_resp = n;
  endtask

  task automatic get_resp(input string name, input int n_resp, input int ack_fall_delay);
    logic [W-1:0] exp;
    int n;
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++;
    if (n_resp < 0) begin
      errors++;
      $display("FAIL %s_resp: dm_resp_o never rose, required response %h", name, exp);
    end else if (dm_resp_data_o !== exp) begin
      errors++;
      $display("FAIL %s_resp: data=%h required %h", name, dm_resp_data_o, exp);
    end
    dtm_resp_ack_i = 1'b1;
    n = 0;
    while (dm_resp_o === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dm_resp_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_resp_drop: dm_resp_o=%b required 0", name, dm_resp_o);
    end
    repeat (ack_fall_delay) @(negedge clk);
    dtm_resp_ack_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({dtm_ack_o, dm_resp_o, dm_resp_data_o, reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b resp=%b rdata=%h req=%b we=%b addr=%h wdata=%h required all 0",
               dtm_ack_o, dm_resp_o, dm_resp_data_o, reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int n, nf, nr, a0;
    bank_on = 1'b1; bank_delay = 2; a0 = acc_count;
    sb.push_back(mk(6'h10, 32'hDEADBEEF, 2'd0));
    raise_req(mk(6'h10, 32'hDEADBEEF, 2'd2));
    wait_ack("write", n);
    checks++;
    if (n != 3) begin errors++; $display("FAIL write_ack_latency: %0d edges required 3", n); end
    release_req(nf, nr);
    get_resp("write", nr, 0);
    checks++;
    if (acc_count != a0 + 1) begin errors++; $display("FAIL write_acc_count: %0d required %0d", acc_count - a0, 1); end
    checks++;
    if (cap_we !== 1'b1 || cap_addr !== 6'h10 || cap_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_bank_fields: we=%b addr=%h wdata=%h required 1 10 deadbeef", cap_we, cap_addr, cap_wdata);
    end
    checks++;
    if (hi_cyc != 3 || stable_bad) begin
      errors++;
      $display("FAIL write_req_shape: high=%0d unstable=%0d required 3 0", hi_cyc, stable_bad);
    end
  endtask

  task automatic test_read();
    int n, nf, nr;
    bank_on = 1'b1; bank_delay = 0; bank_rdata = 32'h00000A5A;
    sb.push_back(mk(6'h11, 32'h00000A5A, 2'd0));
    raise_req(mk(6'h11, 32'h12345678, 2'd1));
    wait_ack("read", n);
    release_req(nf, nr);
    checks++;
    if (nf != 3 || nr != 5) begin
      errors++;
      $display("FAIL read_latency: ack_fall=%0d resp_rise=%0d required 3 5", nf, nr);
    end
    get_resp("read", nr, 0);
    checks++;
    if (cap_we !== 1'b0 || stable_bad || hi_cyc != 1) begin
      errors++;
      $display("FAIL read_bank: we=%b unstable=%0d high=%0d required 0 0 1", cap_we, stable_bad, hi_cyc);
    end
  endtask

  task automatic test_timeout();
    int n, nf, nr;
    bank_on = 1'b0;
    sb.push_back(mk(6'h20, 32'h0, 2'd2));
    raise_req(mk(6'h20, 32'h0000CAFE, 2'd2));
    wait_ack("timeout", n);
    release_req(nf, nr);
    get_resp("timeout", nr, 0);
    checks++;
    if (hi_cyc != TO) begin errors++; $display("FAIL timeout_req_cycles: %0d required %0d", hi_cyc, TO); end
    bank_on = 1'b1; bank_delay = 1; bank_rdata = 32'h55550001;
    sb.push_back(mk(6'h21, 32'h55550001, 2'd0));
    raise_req(mk(6'h21, 32'h0, 2'd1));
    wait_ack("after_timeout", n);
    release_req(nf, nr);
    get_resp("after_timeout", nr, 0);
    checks++;
    if (hi_cyc != 2) begin errors++; $display("FAIL after_timeout_cycles: %0d required 2", hi_cyc); end
  endtask

  task automatic test_nop_reserved();
    int n, nf, nr, a0;
    a0 = acc_count;
    sb.push_back(mk(6'h05, 32'h0, 2'd0));
    raise_req(mk(6'h05, 32'h00001234, 2'd0));
    wait_ack("nop", n);
    release_req(nf, nr);
    checks++;
    if (nr != 4) begin errors++; $display("FAIL nop_latency: %0d required 4", nr); end
    get_resp("nop", nr, 0);
    sb.push_back(mk(6'h06, 32'h0, 2'd2));
    raise_req(mk(6'h06, 32'h00000099, 2'd3));
    wait_ack("reserved", n);
    release_req(nf, nr);
    get_resp("reserved", nr, 0);
    checks++;
    if (acc_count != a0) begin errors++; $display("FAIL nop_no_access: %0d accesses required 0", acc_count - a0); end
  endtask

  task automatic test_handshake();
    int n, nf, nr, a0;
    bit bad_ack, bad_req;
    logic [W-1:0] exp;
    bank_on = 1'b1; bank_delay = 0;
    // Long request hold: ack stays up, nothing reaches the bank
    sb.push_back(mk(6'h30, 32'h00000077, 2'd0));
    raise_req(mk(6'h30, 32'h00000077, 2'd2));
    wait_ack("hold", n);
    a0 = acc_count; bad_ack = 0; bad_req = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dtm_ack_o !== 1'b1) bad_ack = 1;
      if (reg_req_o !== 1'b0) bad_req = 1;
    end
    checks++;
    if (bad_ack || bad_req || acc_count != a0) begin
      errors++;
      $display("FAIL hold_req: ack_dropped=%0d req_seen=%0d required 0 0", bad_ack, bad_req);
    end
    release_req(nf, nr);
    get_resp("hold", nr, 0);
    // Late response-ack release with a second request raised meanwhile
    sb.push_back(mk(6'h31, 32'h00000A5A, 2'd0));
    bank_rdata = 32'h00000A5A;
    raise_req(mk(6'h31, 32'h0, 2'd1));
    wait_ack("late_first", n);
    release_req(nf, nr);
    exp = sb.pop_front();
    checks++;
    if (nr < 0 || dm_resp_data_o !== exp) begin
      errors++;
      $display("FAIL late_first_resp: data=%h required %h", dm_resp_data_o, exp);
    end
    dtm_resp_ack_i = 1'b1;
    n = 0;
    while (dm_resp_o === 1'b1 && n < 40) begin @(negedge clk); n++; end
    sb.push_back(mk(6'h32, 32'h00000088, 2'd0));
    raise_req(mk(6'h32, 32'h00000088, 2'd2));
    a0 = acc_count; bad_ack = 0; bad_req = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (dtm_ack_o !== 1'b0) bad_ack = 1;
      if (reg_req_o !== 1'b0) bad_req = 1;
    end
    checks++;
    if (bad_ack || bad_req || acc_count != a0) begin
      errors++;
      $display("FAIL late_second_blocked: ack_seen=%0d req_seen=%0d required 0 0", bad_ack, bad_req);
    end
    dtm_resp_ack_i = 1'b0;
    wait_ack("late_second", n);
    release_req(nf, nr);
    get_resp("late_second", nr, 0);
  endtask

  task automatic test_reset_mid();
    int n, nf, nr;
    bit bad_resp;
    bank_on = 1'b0;
    raise_req(mk(6'h03, 32'h00000005, 2'd2));
    wait_ack("abort", n);
    dtm_req_i = 1'b0;
    n = 0;
    while (reg_req_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (reg_req_o !== 1'b1) begin errors++; $display("FAIL abort_access_start: reg_req_o=%b required 1", reg_req_o); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({dtm_ack_o, dm_resp_o, dm_resp_data_o, reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: req=%b resp=%b ack=%b rdata=%h required all 0",
               reg_req_o, dm_resp_o, dtm_ack_o, dm_resp_data_o);
    end
    @(negedge clk);
    rst = 1'b0;
    bad_resp = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dm_resp_o !== 1'b0 || reg_req_o !== 1'b0) bad_resp = 1;
    end
    checks++;
    if (bad_resp) begin errors++; $display("FAIL abort_no_resp: activity after reset required none"); end
    bank_on = 1'b1; bank_delay = 0;
    sb.push_back(mk(6'h04, 32'h00000001, 2'd0));
    raise_req(mk(6'h04, 32'h00000001, 2'd2));
    wait_ack("post_reset", n);
    release_req(nf, nr);
    get_resp("post_reset", nr, 0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_nop_reserved();
    test_handshake();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
